// File: rtl/rtc_timekeeper.sv
// Real-time clock core: derives a 1 s tick from the system clock and keeps hh:mm:ss,
// with handshaked time load, programmable alarm and a 12/24-hour display view.
module rtc_timekeeper #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       mode_12h,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [5:0] load_sec,
    input  logic [5:0] load_min,
    input  logic [4:0] load_hr,
    output logic       load_err,
    input  logic       alarm_wr,
    input  logic [5:0] alarm_min,
    input  logic [4:0] alarm_hr,
    input  logic       alarm_en,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic [4:0] disp_hours,
    output logic       pm,
    output logic       tick_1s,
    output logic       day_wrap,
    output logic       alarm_hit
);
    localparam int             PW        = $clog2(CLK_HZ);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_HZ - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc;
    logic [5:0]    alm_min_r;
    logic [4:0]    alm_hr_r;
    logic [5:0]    sec_nx, min_nx;
    logic [4:0]    hr_nx;
    logic          wrap_nx;
    logic          tick, load_acc, load_legal, load_ok, load_bad, alm_legal;

    assign tick       = en && (presc == PRESC_MAX);
    assign load_ready = (state_q == IDLE);
    assign load_acc   = load_valid && load_ready;
    assign load_legal = (load_sec <= 6'd59) && (load_min <= 6'd59) && (load_hr <= 5'd23);
    assign load_ok    = load_acc && load_legal;
    assign load_bad   = load_acc && !load_legal;
    assign alm_legal  = (alarm_min <= 6'd59) && (alarm_hr <= 5'd23);

    // BUSY only exists to hold load_ready low for the cycle after an accept
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_valid) state_d = BUSY;
            BUSY:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sec_nx  = seconds + 6'd1;
        min_nx  = minutes;
        hr_nx   = hours;
        wrap_nx = 1'b0;
        if (seconds == 6'd59) begin
            sec_nx = 6'd0;
            min_nx = minutes + 6'd1;
            if (minutes == 6'd59) begin
                min_nx = 6'd0;
                hr_nx  = hours + 5'd1;
                if (hours == 5'd23) begin
                    hr_nx   = 5'd0;
                    wrap_nx = 1'b1;
                end
            end
        end
    end

    // A legal load pre-empts a coincident tick; an illegal one lets it through
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            presc     <= '0;
            seconds   <= '0;
            minutes   <= '0;
            hours     <= '0;
            tick_1s   <= 1'b0;
            day_wrap  <= 1'b0;
            alarm_hit <= 1'b0;
            load_err  <= 1'b0;
            alm_min_r <= '0;
            alm_hr_r  <= '0;
        end else begin
            tick_1s   <= 1'b0;
            day_wrap  <= 1'b0;
            alarm_hit <= 1'b0;
            load_err  <= load_bad;
            if (load_ok) begin
                seconds <= load_sec;
                minutes <= load_min;
                hours   <= load_hr;
                presc   <= '0;
            end else if (tick) begin
                seconds   <= sec_nx;
                minutes   <= min_nx;
                hours     <= hr_nx;
                presc     <= '0;
                tick_1s   <= 1'b1;
                day_wrap  <= wrap_nx;
                alarm_hit <= alarm_en && (sec_nx == 6'd0) &&
                             (min_nx == alm_min_r) && (hr_nx == alm_hr_r);
            end else if (en) begin
                presc <= presc + PW'(1);
            end
            if (alarm_wr && alm_legal) begin
                alm_min_r <= alarm_min;
                alm_hr_r  <= alarm_hr;
            end
        end
    end

    always_comb begin
        disp_hours = hours;
        if (mode_12h) begin
            if (hours == 5'd0)       disp_hours = 5'd12;
            else if (hours > 5'd12)  disp_hours = hours - 5'd12;
        end
    end

    assign pm = (hours >= 5'd12);

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Scoreboard bench for rtc_timekeeper at CLK_HZ = 4: expected strobe events are queued
// by the stimulus and popped by a monitor whenever any strobe is seen.
module tb_rtc_timekeeper;
    localparam int CLK_HZ = 4;

    logic       Clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       en = 1'b0, mode_12h = 1'b1, load_valid = 1'b0;
    logic       load_ready, load_err;
    logic [5:0] load_sec = '0, load_min = '0;
    logic [4:0] load_hr = '0;
    logic       alarm_wr = 1'b0, alarm_en = 1'b0;
    logic [5:0] alarm_min = '0;
    logic [4:0] alarm_hr = '0;
    logic [5:0] seconds, minutes;
    logic [4:0] hours, disp_hours;
    logic       pm, tick_1s, day_wrap, alarm_hit;

    rtc_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
        .Clk(Clk), .reset_n(reset_n), .en(en), .mode_12h(mode_12h),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr), .load_err(load_err),
        .alarm_wr(alarm_wr), .alarm_min(alarm_min), .alarm_hr(alarm_hr), .alarm_en(alarm_en),
        .seconds(seconds), .minutes(minutes), .hours(hours),
        .disp_hours(disp_hours), .pm(pm),
        .tick_1s(tick_1s), .day_wrap(day_wrap), .alarm_hit(alarm_hit)
    );

    always #5 Clk = ~Clk;

    // {tick_1s, day_wrap, alarm_hit, load_err, seconds, minutes, hours}
    typedef logic [21:0] ev_t;
    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    function automatic ev_t mk(input logic t, dw, ah, le, input int s, m, h);
        return {t, dw, ah, le, 6'(s), 6'(m), 5'(h)};
    endfunction

    always @(negedge Clk) begin
        if (tick_1s || day_wrap || alarm_hit || load_err) begin
            ev_t act, expv;
            act = {tick_1s, day_wrap, alarm_hit, load_err, seconds, minutes, hours};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL strobe_unexpected: got %h, none required", act);
            end else begin
                expv = exp_q.pop_front();
                if (act !== expv) begin
                    failures++;
                    $display("FAIL strobe_event: got %h, required %h", act, expv);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic do_load(input int h, m, s);
        load_hr = 5'(h); load_min = 6'(m); load_sec = 6'(s); load_valid = 1'b1;
        @(posedge Clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic chk_time(input string name, input int h, m, s);
        chk(name, {hours, minutes, seconds}, {5'(h), 6'(m), 6'(s)});
    endtask

    task automatic wr_alarm(input int h, m);
        alarm_hr = 5'(h); alarm_min = 6'(m); alarm_wr = 1'b1;
        step(1);
        alarm_wr = 1'b0;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        step(2);
        chk_time("reset_time", 0, 0, 0);
        chk("reset_ready", load_ready, 1);
        chk("reset_strobes", {tick_1s, day_wrap, alarm_hit, load_err}, 0);
        chk("reset_disp12", disp_hours, 12);
        chk("reset_pm", pm, 0);

        // free run: 60 ticks in 240 cycles
        for (int i = 1; i <= 60; i++) exp_q.push_back(mk(1, 0, 0, 0, i % 60, i / 60, 0));
        reset_n = 1'b1; en = 1'b1;
        step(240);
        en = 1'b0;
        chk_time("run_60s", 0, 1, 0);
        chk("run_disp12", disp_hours, 12);
        chk("run_pm", pm, 0);

        // day wrap
        do_load(23, 59, 58);
        chk_time("load_2359", 23, 59, 58);
        exp_q.push_back(mk(1, 0, 0, 0, 59, 59, 23));
        exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        en = 1'b1; step(8); en = 1'b0;
        chk_time("after_wrap", 0, 0, 0);

        // display view
        do_load(13, 5, 7);
        chk("disp_12h", disp_hours, 1);
        chk("pm_12h", pm, 1);
        mode_12h = 1'b0; #1;
        chk("disp_24h", disp_hours, 13);
        chk("pm_24h", pm, 1);
        step(1);

        // illegal load, then back-to-back loads
        exp_q.push_back(mk(0, 0, 0, 1, 7, 5, 13));
        do_load(13, 5, 60);
        chk("err_ready_low", load_ready, 0);
        chk_time("err_time_kept", 13, 5, 7);
        step(1);
        chk("err_ready_back", load_ready, 1);
        chk("err_one_cycle", load_err, 0);
        load_hr = 5'd1; load_min = 6'd2; load_sec = 6'd3; load_valid = 1'b1;
        step(1);
        load_hr = 5'd4; load_min = 6'd5; load_sec = 6'd6;
        chk_time("b2b_first", 1, 2, 3);
        chk("b2b_busy", load_ready, 0);
        step(1);
        chk_time("b2b_busy_ignored", 1, 2, 3);
        chk("b2b_idle", load_ready, 1);
        step(1);
        load_valid = 1'b0;
        chk_time("b2b_second", 4, 5, 6);
        step(1);

        // alarm: legal write, illegal write ignored
        wr_alarm(7, 30);
        wr_alarm(8, 60);
        alarm_en = 1'b1;
        do_load(7, 29, 59);
        exp_q.push_back(mk(1, 0, 1, 0, 0, 30, 7));
        en = 1'b1; step(4); en = 1'b0;
        alarm_en = 1'b0;
        do_load(7, 29, 59);
        exp_q.push_back(mk(1, 0, 0, 0, 0, 30, 7));
        en = 1'b1; step(4); en = 1'b0;
        alarm_en = 1'b1;
        do_load(7, 30, 0);
        chk("load_on_alarm", alarm_hit, 0);
        en = 1'b1; step(3); en = 1'b0;
        alarm_en = 1'b0;

        // legal load coincident with tick, then prescaler restart
        do_load(2, 0, 0);
        en = 1'b1; step(3);
        do_load(3, 0, 0);
        chk_time("load_beats_tick", 3, 0, 0);
        chk("load_no_tick", tick_1s, 0);
        exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 3));
        step(4);
        // illegal load coincident with tick: tick proceeds
        step(3);
        exp_q.push_back(mk(1, 0, 0, 1, 2, 0, 3));
        do_load(24, 0, 0);
        en = 1'b0;
        chk_time("bad_load_tick", 3, 0, 2);

        // freeze with en = 0
        en = 1'b1; step(2); en = 1'b0;
        step(10);
        chk_time("frozen", 3, 0, 2);
        exp_q.push_back(mk(1, 0, 0, 0, 3, 0, 3));
        en = 1'b1; step(2); en = 1'b0;
        chk_time("resume", 3, 0, 3);

        // asynchronous reset mid-count
        mode_12h = 1'b1;
        do_load(5, 6, 7);
        en = 1'b1; step(2);
        #2 reset_n = 1'b0;
        #1;
        chk_time("areset_time", 0, 0, 0);
        chk("areset_ready", load_ready, 1);
        chk("areset_disp", {disp_hours, pm}, {5'd12, 1'b0});
        en = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(2);
        chk_time("areset_hold", 0, 0, 0);

        @(negedge Clk); #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_timekeeper.md
# rtc_timekeeper

Parametrised real-time-clock core that runs from the system clock rather than a dedicated 1 Hz clock. It derives its own one-second tick with an internal prescaler and keeps a 24-hour hh:mm:ss count. It also provides count-enable, validated time load over a valid/ready handshake, a 12/24-hour display view, a programmable alarm, and day-wrap/tick strobes. It sits between the board clock and the display/alarm logic.

## Interface
- CLK_HZ, 50_000_000, system clock cycles per second; ≥2; prescaler counter width = $clog2(CLK_HZ)
- Clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  count enable; 0 freezes prescaler and time
- mode_12h  in  1  display view select; 1 = 12-hour, 0 = 24-hour
- load_valid  in  1  time-load request
- load_ready  out  1  core can accept a load
- load_sec / load_min  in  6 each  time to load
- load_hr  in  5  time to load, 0–23
- load_err  out  1  one-cycle pulse: last accepted load was illegal and was discarded
- alarm_wr  in  1  one-cycle strobe: capture alarm_min/alarm_hr
- alarm_min  in  6  alarm minute
- alarm_hr  in  5  alarm hour
- alarm_en  in  1  alarm arming
- seconds / minutes  out  6 each  current time
- hours  out  5  current time, 24-hour
- disp_hours  out  5  hour value in the selected view
- pm  out  1  hours ≥ 12
- tick_1s  out  1  one-cycle pulse per second advanced
- day_wrap  out  1  one-cycle pulse on 23:59:59→00:00:00
- alarm_hit  out  1  one-cycle pulse on alarm match

## Operation
- Reset values:
  - time 00:00:00; prescaler 0; alarm 00:00
  - tick_1s, day_wrap, alarm_hit, load_err = 0
  - FSM = IDLE, so load_ready = 1
  - disp_hours = 12 when mode_12h = 1, else 0; pm = 0
- Prescaler:
  - Counts 0..CLK_HZ-1 while en = 1.
  - The internal tick fires on the edge where the count equals CLK_HZ-1; the count returns to 0 on that edge.
- Time advance on tick:
  - seconds +1; 59→0 carries into minutes.
  - minutes 59→0 carries into hours.
  - hours 23→0 asserts day_wrap.
  - All fields update on the same edge.
- en = 0: prescaler, time and strobes hold; pending loads and alarm writes are still serviced.
- Load FSM, two states:
  - IDLE: load_ready = 1. On load_valid & load_ready, go to BUSY.
    - Legal load (sec ≤ 59, min ≤ 59, hr ≤ 23): time takes the load values and the prescaler clears to 0.
    - Illegal load: time is unchanged and load_err pulses.
  - BUSY: load_ready = 0 for exactly one cycle, then return to IDLE.
  - load_valid is ignored while in BUSY.
- Alarm write:
  - On alarm_wr, capture alarm_min/alarm_hr only if min ≤ 59 and hr ≤ 23; otherwise the alarm registers are unchanged.
  - Alarm writes do not interact with the load FSM.
- Alarm hit:
  - Fires when a tick advances the time to alarm_hr:alarm_min:00 and alarm_en = 1.
  - A load that lands exactly on the alarm time does not fire.
  - Alarm seconds are always 00.
- Display view (combinational from hours and mode_12h):
  - mode_12h = 1: 0→12, 1–12→unchanged, 13–23→hours-12.
  - mode_12h = 0: disp_hours = hours.
  - pm = (hours ≥ 12) in both modes.
- Simultaneous events:
  - Accepted load and tick on the same edge: the load wins; no advance and no tick_1s, day_wrap or alarm_hit.
  - Illegal load and tick on the same edge: the tick proceeds normally.
- Reset mid-operation: asynchronous return to the reset values listed above; any load in progress is discarded.

## Timing
- Every output except disp_hours and pm is registered.
- Tick edge N: time updates on edge N. tick_1s, day_wrap and alarm_hit are high for the cycle after edge N, together with the new time.
- First tick after reset or after a legal load: exactly CLK_HZ enabled cycles later.
- Load latency: values are visible the cycle after the accepting edge. load_ready is low that same cycle. The next load can be accepted 2 cycles after the previous one.
- load_err is high for the cycle after the accepting edge.

## Test plan
- CLK_HZ = 4, reset release, en = 1 -> tick_1s every 4 cycles; after 60 ticks the time is 00:01:00; disp_hours = 12, pm = 0.
- Load 23:59:58, then 2 ticks -> 23:59:59, then 00:00:00 with day_wrap and tick_1s high together for one cycle.
- Load 13:05:07 with mode_12h = 1 -> disp_hours = 1, pm = 1. Switch to mode_12h = 0 -> disp_hours = 13.
- Load sec = 60 -> load_err pulses 1 cycle, time unchanged, load_ready low 1 cycle. Back-to-back load_valid -> second load accepted 2 cycles after the first.
- Alarm 07:30, alarm_en = 1, load 07:29:59 -> alarm_hit on the next tick. Repeat with alarm_en = 0 -> no hit. Load 07:30:00 directly -> no hit.
- Legal load and tick on the same edge -> loaded value kept, no tick_1s. Assert reset_n low mid-count -> all outputs return to reset values immediately. en = 0 for 10 cycles -> time and prescaler frozen.
